// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB: drives the TLB ports for one
// EXEC cycle per request and returns the CSR write-back values as a one-cycle response.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_op,
    input  logic [4:0]    req_inv_op,
    input  logic [9:0]    req_inv_asid,
    input  logic [18:0]   req_inv_vppn,
    input  logic [18:0]   csr_ehi_vppn,
    input  logic [9:0]    csr_asid,
    input  logic [IW-1:0] csr_idx,
    input  logic [5:0]    csr_ps,
    input  logic          csr_ne,
    input  logic          csr_refill,
    input  logic [31:0]   csr_elo0,
    input  logic [31:0]   csr_elo1,
    output logic          s_sel,
    output logic [18:0]   s_vppn,
    output logic [9:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic [IW-1:0] r_index,
    input  logic          r_e,
    input  logic          r_g,
    input  logic [18:0]   r_vppn,
    input  logic [5:0]    r_ps,
    input  logic [9:0]    r_asid,
    input  logic [25:0]   r_lo0,
    input  logic [25:0]   r_lo1,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic          w_e,
    output logic          w_g,
    output logic [18:0]   w_vppn,
    output logic [5:0]    w_ps,
    output logic [9:0]    w_asid,
    output logic [25:0]   w_lo0,
    output logic [25:0]   w_lo1,
    output logic          invtlb_valid,
    output logic [4:0]    invtlb_op,
    output logic          resp_valid,
    output logic [2:0]    resp_op,
    output logic          resp_ine,
    output logic          resp_ne,
    output logic [IW-1:0] resp_idx,
    output logic [5:0]    resp_ps,
    output logic [18:0]   resp_vppn,
    output logic [9:0]    resp_asid,
    output logic [31:0]   resp_elo0,
    output logic [31:0]   resp_elo1
);

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t        state_reg;
    logic          req_ready_reg;
    logic [IW-1:0] fill_ptr_reg;

    logic [2:0]    op_reg;
    logic          ine_reg;
    logic [18:0]   vppn_reg;
    logic [9:0]    asid_reg;
    logic [IW-1:0] idx_reg;
    logic [5:0]    ps_reg;
    logic          ne_reg;
    logic [31:0]   elo0_reg;
    logic [31:0]   elo1_reg;

    logic          s_sel_reg;
    logic [18:0]   s_vppn_reg;
    logic [9:0]    s_asid_reg;
    logic [IW-1:0] r_index_reg;
    logic          we_reg;
    logic [IW-1:0] w_index_reg;
    logic          w_e_reg;
    logic          w_g_reg;
    logic [18:0]   w_vppn_reg;
    logic [5:0]    w_ps_reg;
    logic [9:0]    w_asid_reg;
    logic [25:0]   w_lo0_reg;
    logic [25:0]   w_lo1_reg;
    logic          inv_valid_reg;
    logic [4:0]    inv_op_reg;

    logic          resp_valid_reg;
    logic [2:0]    resp_op_reg;
    logic          resp_ine_reg;
    logic          resp_ne_reg;
    logic [IW-1:0] resp_idx_reg;
    logic [5:0]    resp_ps_reg;
    logic [18:0]   resp_vppn_reg;
    logic [9:0]    resp_asid_reg;
    logic [31:0]   resp_elo0_reg;
    logic [31:0]   resp_elo1_reg;

    // TLBELO {PPN[27:8],G[6],MAT[5:4],PLV[3:2],D[1],V[0]} <-> TLB {ppn,plv,mat,d,v}
    logic [31:0] csr_elo [2];
    logic [25:0] csr_lo  [2];
    logic [25:0] rd_lo   [2];
    logic [31:0] rd_elo  [2];

    assign csr_elo[0] = csr_elo0;
    assign csr_elo[1] = csr_elo1;
    assign rd_lo[0]   = r_lo0;
    assign rd_lo[1]   = r_lo1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_elo
            assign csr_lo[gi] = {csr_elo[gi][27:8], csr_elo[gi][3:2],
                                 csr_elo[gi][5:4], csr_elo[gi][1:0]};
            assign rd_elo[gi] = {4'b0, rd_lo[gi][25:6], 1'b0, r_g,
                                 rd_lo[gi][3:2], rd_lo[gi][5:4], rd_lo[gi][1:0]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        // TLB-facing strobes and operands only live for the single EXEC cycle
        s_sel_reg     <= 1'b0;
        s_vppn_reg    <= '0;
        s_asid_reg    <= '0;
        r_index_reg   <= '0;
        we_reg        <= 1'b0;
        w_index_reg   <= '0;
        w_e_reg       <= 1'b0;
        w_g_reg       <= 1'b0;
        w_vppn_reg    <= '0;
        w_ps_reg      <= '0;
        w_asid_reg    <= '0;
        w_lo0_reg     <= '0;
        w_lo1_reg     <= '0;
        inv_valid_reg <= 1'b0;
        inv_op_reg    <= '0;
        resp_valid_reg <= 1'b0;
        if (!resetn) begin
            state_reg     <= ST_IDLE;
            req_ready_reg <= 1'b1;
            fill_ptr_reg  <= '0;
            resp_op_reg   <= '0;
            resp_ine_reg  <= 1'b0;
            resp_ne_reg   <= 1'b0;
            resp_idx_reg  <= '0;
            resp_ps_reg   <= '0;
            resp_vppn_reg <= '0;
            resp_asid_reg <= '0;
            resp_elo0_reg <= '0;
            resp_elo1_reg <= '0;
        end else begin
            unique case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_reg     <= ST_EXEC;
                        req_ready_reg <= 1'b0;
                        op_reg        <= req_op;
                        ine_reg       <= (req_op > OP_INV) ||
                                         ((req_op == OP_INV) && (req_inv_op > 5'd6));
                        vppn_reg      <= csr_ehi_vppn;
                        asid_reg      <= csr_asid;
                        idx_reg       <= csr_idx;
                        ps_reg        <= csr_ps;
                        ne_reg        <= csr_ne;
                        elo0_reg      <= csr_elo0;
                        elo1_reg      <= csr_elo1;
                        case (req_op)
                            OP_SRCH: begin
                                s_sel_reg  <= 1'b1;
                                s_vppn_reg <= csr_ehi_vppn;
                                s_asid_reg <= csr_asid;
                            end
                            OP_RD: r_index_reg <= csr_idx;
                            OP_WR, OP_FILL: begin
                                we_reg      <= 1'b1;
                                w_index_reg <= (req_op == OP_WR) ? csr_idx : fill_ptr_reg;
                                w_e_reg     <= csr_refill | ~csr_ne;
                                w_g_reg     <= csr_elo0[6] & csr_elo1[6];
                                w_vppn_reg  <= csr_ehi_vppn;
                                w_ps_reg    <= csr_ps;
                                w_asid_reg  <= csr_asid;
                                w_lo0_reg   <= csr_lo[0];
                                w_lo1_reg   <= csr_lo[1];
                            end
                            OP_INV: begin
                                if (req_inv_op <= 5'd6) begin
                                    inv_valid_reg <= 1'b1;
                                    inv_op_reg    <= req_inv_op;
                                    s_sel_reg     <= 1'b1;
                                    s_vppn_reg    <= req_inv_vppn;
                                    s_asid_reg    <= req_inv_asid;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_EXEC: begin
                    state_reg      <= ST_RESP;
                    resp_valid_reg <= 1'b1;
                    resp_op_reg    <= op_reg;
                    resp_ine_reg   <= ine_reg;
                    resp_ne_reg    <= ne_reg;
                    resp_idx_reg   <= idx_reg;
                    resp_ps_reg    <= ps_reg;
                    resp_vppn_reg  <= vppn_reg;
                    resp_asid_reg  <= asid_reg;
                    resp_elo0_reg  <= elo0_reg;
                    resp_elo1_reg  <= elo1_reg;
                    if (op_reg == OP_FILL) begin
                        fill_ptr_reg <= fill_ptr_reg + IW'(1);
                    end
                    if (op_reg == OP_SRCH) begin
                        resp_ne_reg  <= ~s_found;
                        resp_idx_reg <= s_found ? s_index : idx_reg;
                    end else if (op_reg == OP_RD) begin
                        resp_ne_reg   <= ~r_e;
                        resp_ps_reg   <= r_e ? r_ps   : '0;
                        resp_vppn_reg <= r_e ? r_vppn : '0;
                        resp_asid_reg <= r_e ? r_asid : '0;
                        resp_elo0_reg <= r_e ? rd_elo[0] : '0;
                        resp_elo1_reg <= r_e ? rd_elo[1] : '0;
                    end
                end
                ST_RESP: begin
                    state_reg     <= ST_IDLE;
                    req_ready_reg <= 1'b1;
                    resp_op_reg   <= '0;
                    resp_ine_reg  <= 1'b0;
                    resp_ne_reg   <= 1'b0;
                    resp_idx_reg  <= '0;
                    resp_ps_reg   <= '0;
                    resp_vppn_reg <= '0;
                    resp_asid_reg <= '0;
                    resp_elo0_reg <= '0;
                    resp_elo1_reg <= '0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Strobes are masked by resetn so a reset landing mid-operation cannot commit
    assign we           = we_reg & resetn;
    assign invtlb_valid = inv_valid_reg & resetn;
    assign resp_valid   = resp_valid_reg & resetn;

    assign req_ready  = req_ready_reg;
    assign s_sel      = s_sel_reg;
    assign s_vppn     = s_vppn_reg;
    assign s_asid     = s_asid_reg;
    assign r_index    = r_index_reg;
    assign w_index    = w_index_reg;
    assign w_e        = w_e_reg;
    assign w_g        = w_g_reg;
    assign w_vppn     = w_vppn_reg;
    assign w_ps       = w_ps_reg;
    assign w_asid     = w_asid_reg;
    assign w_lo0      = w_lo0_reg;
    assign w_lo1      = w_lo1_reg;
    assign invtlb_op  = inv_op_reg;
    assign resp_op    = resp_op_reg;
    assign resp_ine   = resp_ine_reg;
    assign resp_ne    = resp_ne_reg;
    assign resp_idx   = resp_idx_reg;
    assign resp_ps    = resp_ps_reg;
    assign resp_vppn  = resp_vppn_reg;
    assign resp_asid  = resp_asid_reg;
    assign resp_elo0  = resp_elo0_reg;
    assign resp_elo1  = resp_elo1_reg;

endmodule
